// File: rtl/clock_pkg.sv
// Shared definitions for the clock divider bank: control FSM encoding
// and the configuration-request rejection check.
package clock_pkg;

    // Control FSM states; exposed on the bank's state_dbg output.
    typedef enum logic [1:0] {
        ST_LOCKING = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_APPLY   = 2'd2
    } ctrl_state_e;

    // A request is rejected when it targets a channel that does not exist,
    // or asks for a phase that an enabled channel's counter can never reach.
    // Arguments are zero-extended to 32 bits by the caller.
    function automatic logic cfg_is_rejected(
        input logic [31:0] channel,
        input logic [31:0] channels,
        input logic [31:0] divide,
        input logic [31:0] phase
    );
        return (channel >= channels) || ((divide != 32'd0) && (phase >= divide));
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divided-enable channel: a wrapping counter compared against the
// divide and phase values, driving registered enable and level outputs.
module clock_divider_channel #(
    parameter int CounterWidth = 8,
    parameter int ResetDivide  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load,
    input  logic [CounterWidth-1:0] load_divide,
    input  logic [CounterWidth-1:0] load_phase,
    output logic                    enable,
    output logic                    level
);

    logic [CounterWidth-1:0] divide;
    logic [CounterWidth-1:0] phase;
    logic [CounterWidth-1:0] count;
    logic [CounterWidth:0]   half;

    // High-time threshold, one bit wider so divide = all-ones cannot overflow.
    assign half = ({1'b0, divide} + {{CounterWidth{1'b0}}, 1'b1}) >> 1;

    // Counter, configuration registers and registered compare outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divide <= CounterWidth'(ResetDivide);
            phase  <= '0;
            count  <= '0;
            enable <= 1'b0;
            level  <= 1'b0;
        end else begin
            enable <= (divide != '0) && (count == phase);
            level  <= (divide != '0) && ({1'b0, count} < half);
            if (load) begin
                divide <= load_divide;
                phase  <= load_phase;
                count  <= '0;
            end else if ((divide == '0) || (count == divide - CounterWidth'(1))) begin
                count <= '0;
            end else begin
                count <= count + CounterWidth'(1);
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent clock-enable dividers sharing one configuration port
// and a lock indicator that asserts once no channel has been reconfigured
// for LockCycles cycles.
//
// Configuration handshake: a request transfers on a rising edge where
// cfg_valid and cfg_ready are both 1; cfg_* are sampled only on that edge.
// cfg_valid may be held while cfg_ready is 0 and the request waits.
module clock_divider_bank
    import clock_pkg::*;
#(
    parameter int Channels     = 4,
    parameter int CounterWidth = 8,
    parameter int LockCycles   = 16,
    parameter int ResetDivide  = 2,
    localparam int ChanW       = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [ChanW-1:0]        cfg_channel,
    input  logic [CounterWidth-1:0] cfg_divide,
    input  logic [CounterWidth-1:0] cfg_phase,
    output logic                    cfg_error,
    output logic                    locked,
    output logic [Channels-1:0]     enable,
    output logic [Channels-1:0]     level,
    output ctrl_state_e             state_dbg
);

    localparam int LockW = $clog2(LockCycles + 1);
    localparam logic [LockW-1:0] LockLast = LockW'(LockCycles - 1);

    ctrl_state_e      state;
    logic [LockW-1:0] lock_cnt;
    logic             accept;
    logic             reject;
    logic             apply;

    assign accept    = cfg_valid && cfg_ready;
    assign reject    = cfg_is_rejected(32'(cfg_channel), 32'(Channels),
                                       32'(cfg_divide), 32'(cfg_phase));
    assign apply     = accept && !reject;
    assign state_dbg = state;

    // Control FSM: lock counting, request application and registered status.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_LOCKING;
            lock_cnt  <= '0;
            cfg_ready <= 1'b0;
            cfg_error <= 1'b0;
            locked    <= 1'b0;
        end else begin
            cfg_error <= accept && reject;
            case (state)
                ST_LOCKING: begin
                    if (apply) begin
                        state     <= ST_APPLY;
                        lock_cnt  <= '0;
                        cfg_ready <= 1'b0;
                        locked    <= 1'b0;
                    end else if (lock_cnt == LockLast) begin
                        state     <= ST_LOCKED;
                        cfg_ready <= 1'b1;
                        locked    <= 1'b1;
                    end else begin
                        lock_cnt  <= lock_cnt + LockW'(1);
                        cfg_ready <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (apply) begin
                        state     <= ST_APPLY;
                        lock_cnt  <= '0;
                        cfg_ready <= 1'b0;
                        locked    <= 1'b0;
                    end else begin
                        cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_LOCKING;
                    cfg_ready <= 1'b1;
                    locked    <= 1'b0;
                end
            endcase
        end
    end

    // One divider per channel; only the addressed channel sees a load.
    for (genvar i = 0; i < Channels; i++) begin : g_chan
        clock_divider_channel #(
            .CounterWidth(CounterWidth),
            .ResetDivide (ResetDivide)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .load       (apply && (cfg_channel == ChanW'(i))),
            .load_divide(cfg_divide),
            .load_phase (cfg_phase),
            .enable     (enable[i]),
            .level      (level[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed bench for clock_divider_bank with default parameters.
module tb_clock_divider_bank;
    import clock_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_channel;
    logic [7:0]  cfg_divide;
    logic [7:0]  cfg_phase;
    logic        cfg_error;
    logic        locked;
    logic [3:0]  enable;
    logic [3:0]  level;
    ctrl_state_e state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    clock_divider_bank dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_channel(cfg_channel),
        .cfg_divide (cfg_divide),
        .cfg_phase  (cfg_phase),
        .cfg_error  (cfg_error),
        .locked     (locked),
        .enable     (enable),
        .level      (level),
        .state_dbg  (state_dbg)
    );

    // Clock: 10 ns period.
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Holds a request until it transfers; returns in the cycle after the handshake edge.
    task automatic send_cfg(input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] ph);
        bit done = 1'b0;
        cfg_valid   = 1'b1;
        cfg_channel = ch;
        cfg_divide  = dv;
        cfg_phase   = ph;
        for (int k = 0; k < 32 && !done; k++) begin
            if (cfg_ready === 1'b1) done = 1'b1;
            tick();
        end
        cfg_valid = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL send_cfg_timeout got=no_handshake exp=handshake");
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_v;
        logic       exp_l;
        reset = 1'b1;
        #2;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked got=%b exp=0", locked); end
        tests++; if (cfg_error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", cfg_error); end
        tests++; if (enable !== 4'h0) begin fails++; $display("FAIL reset_enable got=%h exp=0", enable); end
        tests++; if (level !== 4'h0) begin fails++; $display("FAIL reset_level got=%h exp=0", level); end
        tests++; if (state_dbg !== ST_LOCKING) begin fails++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_LOCKING); end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp_v = (n % 2 == 1) ? 4'hF : 4'h0;
            exp_l = (n >= 16);
            tests++; if (enable !== exp_v) begin fails++; $display("FAIL default_enable cyc=%0d got=%h exp=%h", n, enable, exp_v); end
            tests++; if (level !== exp_v) begin fails++; $display("FAIL default_level cyc=%0d got=%h exp=%h", n, level, exp_v); end
            tests++; if (locked !== exp_l) begin fails++; $display("FAIL default_locked cyc=%0d got=%b exp=%b", n, locked, exp_l); end
            tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL default_ready cyc=%0d got=%b exp=1", n, cfg_ready); end
        end
    endtask

    task automatic test_config_ch1();
        logic       exp_l, exp_e, exp_v;
        logic [2:0] exp_o;
        send_cfg(2'd1, 8'd5, 8'd3);
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL apply_ready got=%b exp=0", cfg_ready); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL apply_locked got=%b exp=0", locked); end
        tests++; if (state_dbg !== ST_APPLY) begin fails++; $display("FAIL apply_state got=%0d exp=%0d", state_dbg, ST_APPLY); end
        for (int m = 1; m <= 19; m++) begin
            tick();
            exp_l = (m >= 17);
            exp_e = ((m - 1) % 5 == 3);
            exp_v = ((m - 1) % 5 < 3);
            exp_o = (cyc % 2 == 1) ? 3'b111 : 3'b000;
            tests++; if (locked !== exp_l) begin fails++; $display("FAIL ch1_locked m=%0d got=%b exp=%b", m, locked, exp_l); end
            tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL ch1_ready m=%0d got=%b exp=1", m, cfg_ready); end
            tests++; if (enable[1] !== exp_e) begin fails++; $display("FAIL ch1_enable m=%0d got=%b exp=%b", m, enable[1], exp_e); end
            tests++; if (level[1] !== exp_v) begin fails++; $display("FAIL ch1_level m=%0d got=%b exp=%b", m, level[1], exp_v); end
            tests++; if ({enable[3], enable[2], enable[0]} !== exp_o) begin
                fails++; $display("FAIL ch1_others m=%0d got=%b exp=%b", m, {enable[3], enable[2], enable[0]}, exp_o);
            end
        end
    endtask

    task automatic test_reject();
        logic exp_v;
        send_cfg(2'd0, 8'd4, 8'd4);
        tests++; if (cfg_error !== 1'b1) begin fails++; $display("FAIL reject_error got=%b exp=1", cfg_error); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL reject_locked got=%b exp=1", locked); end
        tests++; if (state_dbg !== ST_LOCKED) begin fails++; $display("FAIL reject_state got=%0d exp=%0d", state_dbg, ST_LOCKED); end
        for (int m = 1; m <= 6; m++) begin
            tick();
            exp_v = (cyc % 2 == 1);
            tests++; if (cfg_error !== 1'b0) begin fails++; $display("FAIL reject_error_clear m=%0d got=%b exp=0", m, cfg_error); end
            tests++; if (locked !== 1'b1) begin fails++; $display("FAIL reject_locked_hold m=%0d got=%b exp=1", m, locked); end
            tests++; if (enable[0] !== exp_v) begin fails++; $display("FAIL reject_ch0_enable m=%0d got=%b exp=%b", m, enable[0], exp_v); end
            tests++; if (level[0] !== exp_v) begin fails++; $display("FAIL reject_ch0_level m=%0d got=%b exp=%b", m, level[0], exp_v); end
        end
    endtask

    task automatic test_div0_div1();
        send_cfg(2'd2, 8'd0, 8'd0);
        send_cfg(2'd3, 8'd1, 8'd0);
        for (int m = 1; m <= 12; m++) begin
            tick();
            tests++; if ({level[2], enable[2]} !== 2'b00) begin fails++; $display("FAIL div0_outputs m=%0d got=%b exp=00", m, {level[2], enable[2]}); end
            tests++; if ({level[3], enable[3]} !== 2'b11) begin fails++; $display("FAIL div1_outputs m=%0d got=%b exp=11", m, {level[3], enable[3]}); end
        end
    endtask

    task automatic test_final_cycle();
        logic exp_l;
        send_cfg(2'd1, 8'd5, 8'd3);
        repeat (16) tick();
        tests++; if (state_dbg !== ST_LOCKING) begin fails++; $display("FAIL final_pre_state got=%0d exp=%0d", state_dbg, ST_LOCKING); end
        send_cfg(2'd1, 8'd6, 8'd2);
        tests++; if (state_dbg !== ST_APPLY) begin fails++; $display("FAIL final_state got=%0d exp=%0d", state_dbg, ST_APPLY); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL final_locked got=%b exp=0", locked); end
        for (int m = 1; m <= 17; m++) begin
            tick();
            exp_l = (m >= 17);
            tests++; if (locked !== exp_l) begin fails++; $display("FAIL final_relock m=%0d got=%b exp=%b", m, locked, exp_l); end
        end
    endtask

    task automatic test_reset_in_apply();
        logic [3:0] exp_v;
        send_cfg(2'd0, 8'd7, 8'd2);
        #1;
        reset = 1'b1;
        #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL rst_apply_ready got=%b exp=0", cfg_ready); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_apply_locked got=%b exp=0", locked); end
        tests++; if (enable !== 4'h0) begin fails++; $display("FAIL rst_apply_enable got=%h exp=0", enable); end
        tests++; if (level !== 4'h0) begin fails++; $display("FAIL rst_apply_level got=%h exp=0", level); end
        tests++; if (state_dbg !== ST_LOCKING) begin fails++; $display("FAIL rst_apply_state got=%0d exp=%0d", state_dbg, ST_LOCKING); end
        #1;
        reset = 1'b0;
        cyc   = 0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp_v = (n % 2 == 1) ? 4'hF : 4'h0;
            tests++; if (enable !== exp_v) begin fails++; $display("FAIL rst_apply_div2_enable cyc=%0d got=%h exp=%h", n, enable, exp_v); end
            tests++; if (level !== exp_v) begin fails++; $display("FAIL rst_apply_div2_level cyc=%0d got=%h exp=%h", n, level, exp_v); end
            tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL rst_apply_ready_after cyc=%0d got=%b exp=1", n, cfg_ready); end
            tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rst_apply_locked_after cyc=%0d got=%b exp=0", n, locked); end
        end
    endtask

    initial begin
        cfg_valid   = 1'b0;
        cfg_channel = 2'd0;
        cfg_divide  = 8'd0;
        cfg_phase   = 8'd0;
        test_reset();
        test_config_ch1();
        test_reject();
        test_div0_div1();
        test_final_cycle();
        test_reset_in_apply();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
